adder_tree_sat: RTL and testbench

ADDER_TREE_SAT -- requirements
Module: adder_tree_sat

---
 rtl/adder_pkg.sv | 24 ++
 rtl/adder_pair_stage.sv | 33 +++
 rtl/adder_tree_sat.sv | 111 +++++++++++
 tb/tb_adder_tree_sat.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared helpers for the saturating adder tree: tree depth, saturation limits
// and the bit offset of a channel inside a packed bus.
package adder_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic longint sat_max(input int width);
    return (longint'(1) <<< (width - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int width);
    return -(longint'(1) <<< (width - 1));
  endfunction

  function automatic int chan_lsb(input int chan, input int width);
    return chan * width;
  endfunction

endpackage

// File: rtl/adder_pair_stage.sv
// One tree node: registers the one-bit-grown sum of two signed operands
// together with its valid bit, advancing only when the pipeline is enabled.
module adder_pair_stage #(
  parameter int IN_W = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   a,
  input  logic [IN_W-1:0]   b,
  output logic [IN_W:0]     sum,
  output logic              out_valid
);

  logic [IN_W:0] sum_reg;
  logic          valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (en) begin
      valid_reg <= in_valid;
      // Bubbles leave the data register untouched to save toggling.
      if (in_valid) sum_reg <= {a[IN_W-1], a} + {b[IN_W-1], b};
    end
  end

  assign sum       = sum_reg;
  assign out_valid = valid_reg;

endmodule

// File: rtl/adder_tree_sat.sv
// Pipelined binary adder tree with exact and saturated/wrapped outputs,
// a global-stall valid/ready handshake and a saturating overflow counter.
module adder_tree_sat
  import adder_pkg::*;
#(
  parameter int WIDTH    = 19,
  parameter int CHANNELS = 4,
  parameter int SAT      = 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [CHANNELS*WIDTH-1:0]              in_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [WIDTH-1:0]                       out_sum,
  output logic [WIDTH+clog2(CHANNELS)-1:0]       out_sum_full,
  output logic                                   out_ovf,
  output logic [15:0]                            ovf_count,
  input  logic                                   ovf_clr
);

  localparam int LVL = clog2(CHANNELS);
  localparam int FW  = WIDTH + LVL;
  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));

  logic en;
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  genvar gl, gi;
  generate
    for (gl = 0; gl < LVL; gl++) begin : lvl_g
      localparam int IW = WIDTH + gl;
      localparam int NP = CHANNELS >> (gl + 1);

      logic [2*NP*IW-1:0]   in_bus;
      logic                 in_vld;
      logic [NP*(IW+1)-1:0] sum_bus;
      logic [NP-1:0]        vld_bus;

      if (gl == 0) begin : g_leaf
        assign in_bus = in_data;
        assign in_vld = in_valid;
      end else begin : g_inner
        // All nodes of a level share one valid; the reduction just gathers them.
        assign in_bus = lvl_g[gl-1].sum_bus;
        assign in_vld = &lvl_g[gl-1].vld_bus;
      end

      for (gi = 0; gi < NP; gi++) begin : pair_g
        adder_pair_stage #(.IN_W(IW)) u_pair (
          .clk       (clk),
          .rst_n     (rst_n),
          .en        (en),
          .in_valid  (in_vld),
          .a         (in_bus[chan_lsb(2*gi, IW) +: IW]),
          .b         (in_bus[chan_lsb(2*gi+1, IW) +: IW]),
          .sum       (sum_bus[chan_lsb(gi, IW+1) +: IW+1]),
          .out_valid (vld_bus[gi])
        );
      end
    end
  endgenerate

  logic [FW-1:0]    root_sum;
  logic             root_vld;
  logic             ovf_next;
  logic [WIDTH-1:0] sum_next;

  assign root_sum = lvl_g[LVL-1].sum_bus;
  assign root_vld = &lvl_g[LVL-1].vld_bus;

  // The sum fits WIDTH bits exactly when every bit above the WIDTH sign bit repeats it.
  always_comb begin
    ovf_next = (root_sum[FW-1:WIDTH-1] != {(LVL+1){root_sum[FW-1]}});
    sum_next = root_sum[WIDTH-1:0];
    if ((SAT != 0) && ovf_next) sum_next = root_sum[FW-1] ? SAT_MIN : SAT_MAX;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_sum      <= '0;
      out_sum_full <= '0;
      out_ovf      <= 1'b0;
    end else if (en) begin
      out_valid <= root_vld;
      if (root_vld) begin
        out_sum      <= sum_next;
        out_sum_full <= root_sum;
        out_ovf      <= ovf_next;
      end
    end
  end

  // A clear coinciding with a counted handshake restarts the count at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count <= '0;
    end else if (out_valid && out_ready && out_ovf) begin
      if (ovf_clr)                  ovf_count <= 16'd1;
      else if (ovf_count != 16'hFFFF) ovf_count <= ovf_count + 16'd1;
    end else if (ovf_clr) begin
      ovf_count <= '0;
    end
  end

endmodule

// File: tb/tb_adder_tree_sat.sv
// Directed scoreboard bench: a saturating and a wrapping instance share stimulus,
// expected sums are queued on input handshakes and checked on output handshakes.
module tb_adder_tree_sat;

  localparam int WIDTH    = 19;
  localparam int CHANNELS = 4;
  localparam int LVL      = 2;
  localparam int FW       = WIDTH + LVL;
  localparam longint PMAX = 262143;
  localparam longint NMIN = -262144;

  typedef struct {
    longint full;
    longint sat;
    longint wrp;
    bit     ovf;
    int     cyc;
    bit     lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic ovf_clr = 1'b0;
  logic [CHANNELS*WIDTH-1:0] in_data = '0;

  logic in_ready_s, out_valid_s, out_ovf_s;
  logic [WIDTH-1:0] out_sum_s;
  logic [FW-1:0] out_sum_full_s;
  logic [15:0] ovf_count_s;
  logic in_ready_w, out_valid_w, out_ovf_w;
  logic [WIDTH-1:0] out_sum_w;
  logic [FW-1:0] out_sum_full_w;
  logic [15:0] ovf_count_w;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int model_cnt = 0;
  bit lat_chk = 1'b0;
  bit acc, pop;
  longint ch [CHANNELS];
  longint sets [6][CHANNELS];
  exp_t sb [$];

  always #5 clk = ~clk;

  adder_tree_sat #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SAT(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_sum(out_sum_s), .out_sum_full(out_sum_full_s), .out_ovf(out_ovf_s),
    .ovf_count(ovf_count_s), .ovf_clr(ovf_clr)
  );

  adder_tree_sat #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SAT(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_data(in_data), .out_valid(out_valid_w), .out_ready(out_ready),
    .out_sum(out_sum_w), .out_sum_full(out_sum_full_w), .out_ovf(out_ovf_w),
    .ovf_count(ovf_count_w), .ovf_clr(ovf_clr)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_chans(input longint c0, input longint c1, input longint c2, input longint c3);
    ch[0] = c0; ch[1] = c1; ch[2] = c2; ch[3] = c3;
    for (int k = 0; k < CHANNELS; k++) in_data[k*WIDTH +: WIDTH] = WIDTH'(ch[k]);
  endtask

  function automatic exp_t model();
    exp_t e;
    longint s, w;
    s = 0;
    for (int k = 0; k < CHANNELS; k++) s += ch[k];
    e.full = s;
    e.ovf  = (s > PMAX) || (s < NMIN);
    e.sat  = (s > PMAX) ? PMAX : ((s < NMIN) ? NMIN : s);
    w = s & longint'(524287);
    if (w > PMAX) w -= 524288;
    e.wrp = w;
    e.cyc = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  // Called at a falling edge with inputs already driven; advances one cycle.
  task automatic tick(output bit accepted, output bit popped);
    exp_t e;
    accepted = 1'b0;
    popped   = 1'b0;
    #1;
    if (in_valid && in_ready_s) begin
      e = model();
      e.cyc = cyc;
      e.lat = lat_chk;
      sb.push_back(e);
      accepted = 1'b1;
    end
    if (out_valid_s && out_ready) begin
      popped = 1'b1;
      chk("wrap_out_valid", 64'(out_valid_w), 1);
      if (sb.size() == 0) begin
        chk("output_without_input", 64'(sb.size()), 1);
      end else begin
        e = sb.pop_front();
        chk("sat_out_sum", 64'($signed(out_sum_s)), e.sat);
        chk("wrap_out_sum", 64'($signed(out_sum_w)), e.wrp);
        chk("sat_out_sum_full", 64'($signed(out_sum_full_s)), e.full);
        chk("wrap_out_sum_full", 64'($signed(out_sum_full_w)), e.full);
        chk("sat_out_ovf", 64'(out_ovf_s), 64'(e.ovf));
        chk("wrap_out_ovf", 64'(out_ovf_w), 64'(e.ovf));
        if (e.lat) chk("latency", 64'(cyc - e.cyc), LVL + 1);
        if (e.ovf) model_cnt = ovf_clr ? 1 : ((model_cnt == 65535) ? 65535 : model_cnt + 1);
        else if (ovf_clr) model_cnt = 0;
      end
    end else if (ovf_clr) begin
      model_cnt = 0;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    chk("sat_ovf_count", 64'(ovf_count_s), model_cnt);
    chk("wrap_ovf_count", 64'(ovf_count_w), model_cnt);
  endtask

  task automatic drain(input int max_cycles);
    int g;
    bit a, p;
    in_valid = 1'b0;
    g = 0;
    while (sb.size() > 0 && g < max_cycles) begin
      tick(a, p);
      g++;
    end
    chk("drain_timeout", 64'(sb.size()), 0);
  endtask

  initial begin
    int sent, pops, stall, stall_cycles, guard;
    logic [WIDTH-1:0] held_sum;
    logic [FW-1:0] held_full;
    logic held_ovf;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid_s), 0);
    chk("rst_out_sum", 64'(out_sum_s), 0);
    chk("rst_out_sum_full", 64'(out_sum_full_s), 0);
    chk("rst_out_ovf", 64'(out_ovf_s), 0);
    chk("rst_ovf_count", 64'(ovf_count_s), 0);
    chk("rst_in_ready", 64'(in_ready_s), 1);
    rst_n = 1'b1;

    // Small sum with latency check
    lat_chk = 1'b1;
    in_valid = 1'b1;
    set_chans(1, 1, 1, 1);
    tick(acc, pop);
    drain(10);

    // Positive and negative overflow
    in_valid = 1'b1;
    set_chans(PMAX, PMAX, PMAX, PMAX);
    tick(acc, pop);
    drain(10);
    chk("ovf_count_after_pos", 64'(ovf_count_s), 1);
    in_valid = 1'b1;
    set_chans(NMIN, NMIN, NMIN, NMIN);
    tick(acc, pop);
    drain(10);
    chk("ovf_count_after_neg", 64'(ovf_count_s), 2);

    // Mixed signs, no overflow
    in_valid = 1'b1;
    set_chans(1, -1, -2, 1);
    tick(acc, pop);
    drain(10);

    // Back-to-back stream with a 5-cycle downstream stall after the second output
    lat_chk = 1'b0;
    for (int i = 0; i < 6; i++)
      for (int k = 0; k < CHANNELS; k++)
        sets[i][k] = longint'($urandom_range(0, 524287)) - 262144;
    sent = 0; pops = 0; stall = 0; stall_cycles = 0; guard = 0;
    held_sum = '0; held_full = '0; held_ovf = 1'b0;
    while ((sent < 6 || sb.size() > 0) && guard < 60) begin
      if (sent < 6) begin
        in_valid = 1'b1;
        set_chans(sets[sent][0], sets[sent][1], sets[sent][2], sets[sent][3]);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = (stall == 0);
      if (stall > 0) begin
        #1;
        chk("stall_in_ready", 64'(in_ready_s), 0);
        chk("stall_out_valid", 64'(out_valid_s), 1);
        chk("stall_held_sum", 64'(out_sum_s), 64'(held_sum));
        chk("stall_held_full", 64'(out_sum_full_s), 64'(held_full));
        chk("stall_held_ovf", 64'(out_ovf_s), 64'(held_ovf));
      end
      tick(acc, pop);
      if (stall > 0) begin
        stall--;
        stall_cycles++;
      end
      if (acc) sent++;
      if (pop) begin
        pops++;
        if (pops == 2) begin
          stall = 5;
          held_sum = out_sum_s;
          held_full = out_sum_full_s;
          held_ovf = out_ovf_s;
        end
      end
      guard++;
    end
    out_ready = 1'b1;
    chk("stream_outputs", 64'(pops), 6);
    chk("stream_stall_cycles", 64'(stall_cycles), 5);
    chk("stream_leftover", 64'(sb.size()), 0);

    // Reset with three samples in flight
    in_valid = 1'b1;
    set_chans(PMAX, PMAX, PMAX, PMAX);
    for (int i = 0; i < 3; i++) tick(acc, pop);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid_s), 0);
    chk("midrst_wrap_out_valid", 64'(out_valid_w), 0);
    chk("midrst_ovf_count", 64'(ovf_count_s), 0);
    chk("midrst_out_sum_full", 64'(out_sum_full_s), 0);
    sb.delete();
    model_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(acc, pop);
      chk("post_rst_no_stale", 64'(out_valid_s), 0);
    end
    lat_chk = 1'b1;
    in_valid = 1'b1;
    set_chans(5, 6, 7, 8);
    tick(acc, pop);
    drain(10);

    // Counter saturation, then clear together with an overflowing handshake
    lat_chk = 1'b0;
    in_valid = 1'b1;
    set_chans(PMAX, PMAX, PMAX, PMAX);
    sent = 0; guard = 0;
    while (sent < 65537 && guard < 70000) begin
      tick(acc, pop);
      if (acc) sent++;
      guard++;
    end
    chk("sat_stream_sent", 64'(sent), 65537);
    in_valid = 1'b0;
    guard = 0;
    while (sb.size() > 1 && guard < 20) begin
      tick(acc, pop);
      guard++;
    end
    chk("ovf_count_saturated", 64'(ovf_count_s), 65535);
    chk("last_ovf_output_valid", 64'(out_valid_s), 1);
    ovf_clr = 1'b1;
    tick(acc, pop);
    chk("clr_with_ovf_handshake", 64'(ovf_count_s), 1);
    tick(acc, pop);
    ovf_clr = 1'b0;
    chk("clr_alone", 64'(ovf_count_s), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
